ppi_bus_buffer: RTL
===================

// Module: ppi_bus_buffer
// PURPOSE
//  Clocked, parametrised host data-bus buffer for the PPI core. Replaces the
//  read-only, RD-edge-latched buffer with full read/write handling.
//  Synchronises the host strobes CS/RD/WR into CLK. On a read, serves the
//  selected channel. On a write, queues {A,D_IN} in a small FIFO drained by the
//  internal port logic. Sits between the host pins and the port/control registers.
// PARAMETERS
//  DATA_W       8  data bus width
//  ADDR_W       2  host address width; channel count NCH = 2**ADDR_W
//  WFIFO_DEPTH  4  write-queue entries; must be a power of 2 and >= 2
//  SYNC_STAGES  2  synchroniser flops on CS/RD/WR; must be >= 2
// PORTS
//  CLK       in   1             system clock
//  RST_N     in   1             synchronous reset, active-low
//  CS        in   1             chip select, active-low, asynchronous to CLK
//  RD        in   1             read strobe, active-low, asynchronous
//  WR        in   1             write strobe, active-low, asynchronous
//  A         in   ADDR_W        host address / channel select
//  D_IN      in   DATA_W        host write data
//  D_OUT     out  DATA_W        registered read data to pad
//  D_OE      out  1             pad output enable, active-high
//  RD_DATA   in   NCH*DATA_W    channel read values; channel k is at [k*DATA_W +: DATA_W]
//  RD_SEL    out  NCH           one-hot, 1-cycle pulse marking the channel just read
//  WR_VALID  out  1             write-queue head valid
//  WR_READY  in   1             consumer accepts the head entry
//  WR_ADDR   out  ADDR_W        head entry address
//  WR_DATA   out  DATA_W        head entry data
//  OVF       out  1             sticky flag: a write was dropped because the FIFO was full
//  OVF_CLR   in   1             clears OVF, synchronous
// BEHAVIOUR
//  - Reset (RST_N=0 at a CLK edge):
//    - D_OUT=0, D_OE=0, RD_SEL=0, WR_VALID=0, OVF=0.
//    - FIFO pointers and count are cleared.
//    - Synchroniser flops and edge-history flops are set to 1 (idle).
//  - Reset mid-operation: queued entries are lost. A strobe held low through
//    reset release is seen as one new falling edge after SYNC_STAGES cycles.
//  - Sync: cs_s, rd_s and wr_s are the outputs of SYNC_STAGES flops. A and D_IN
//    are not synchronised: the host holds them stable while its strobe is
//    asserted and for SYNC_STAGES+1 CLK cycles after it.
//  - Read: a read event is rd_s falling while cs_s=0.
//    - On that cycle, D_OUT <= RD_DATA[A] and RD_SEL[A] pulses for 1 cycle.
//    - Latency from the RD pin falling to valid D_OUT is SYNC_STAGES+1 cycles.
//    - D_OUT holds its value between reads.
//  - D_OE <= ~cs_s & ~rd_s & wr_s, registered.
//    - It drops 1 cycle after rd_s or cs_s deasserts.
//    - It is forced to 0 whenever wr_s=0 (bus conflict).
//  - Write: a write event is wr_s rising while cs_s=0 on the previous cycle,
//    i.e. the trailing edge, as on a classic PPI. That cycle pushes {A,D_IN}.
//  - FIFO: circular buffer with WFIFO_DEPTH entries.
//    - Count width is clog2(WFIFO_DEPTH)+1; pointers wrap modulo WFIFO_DEPTH.
//    - A pop occurs when WR_VALID & WR_READY.
//    - WR_VALID = (count != 0). WR_ADDR and WR_DATA present the head entry
//      combinationally from FIFO storage.
//    - Push when full without a pop: the entry is dropped, OVF is set and the
//      count is unchanged.
//    - Push and pop in the same cycle when full: both succeed, count stays at
//      WFIFO_DEPTH, OVF unchanged.
//    - Push and pop in the same cycle when empty: no pop (WR_VALID=0). The push
//      lands and WR_VALID=1 next cycle.
//    - WR_READY while empty has no effect.
//  - OVF: a set event and OVF_CLR in the same cycle leaves OVF=1 (set wins).
//  - Read and write events on the same cycle are handled independently.
//  - Strobe edges seen while cs_s=1 are ignored.
// TESTING
//  1. Reset -> D_OUT=0, D_OE=0, WR_VALID=0, OVF=0. Strobes held high: no
//     RD_SEL pulse and no push.
//  2. RD_DATA ch2=8'hA5, A=2, CS=0, RD pulsed low -> D_OUT=8'hA5 at
//     SYNC_STAGES+1 cycles, RD_SEL=4'b0100 for 1 cycle, D_OE high while RD low.
//  3. Three writes (A=0/8'h11, A=1/8'h22, A=3/8'h33) with WR_READY=0 ->
//     count=3, head=0/8'h11. Then WR_READY=1 -> pops in order over 3 cycles.
//  4. Five writes with WR_READY=0 (depth 4) -> 5th dropped, OVF=1, head
//     unchanged. OVF_CLR -> OVF=0.
//  5. FIFO full with WR_READY=1 on the cycle of a 5th push -> accepted,
//     OVF stays 0. Pointer wrap is checked over 10 push/pop pairs.
//  6. RST_N asserted with 2 entries queued and RD held low -> WR_VALID=0
//     after reset. One read event fires after reset release; a mid-cycle
//     pulse on CS alone causes no action.

Source files
------------

// File: rtl/ppi_bus_buffer.sv
// Host data-bus buffer for the PPI core: synchronises CS/RD/WR into CLK, serves
// channel reads from RD_DATA and queues host writes in a small FIFO.
module ppi_bus_buffer #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned WFIFO_DEPTH = 4,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned NCH        = 2**ADDR_W
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CS,
  input  logic                  RD,
  input  logic                  WR,
  input  logic [ADDR_W-1:0]     A,
  input  logic [DATA_W-1:0]     D_IN,
  output logic [DATA_W-1:0]     D_OUT,
  output logic                  D_OE,
  input  logic [NCH*DATA_W-1:0] RD_DATA,
  output logic [NCH-1:0]        RD_SEL,
  output logic                  WR_VALID,
  input  logic                  WR_READY,
  output logic [ADDR_W-1:0]     WR_ADDR,
  output logic [DATA_W-1:0]     WR_DATA,
  output logic                  OVF,
  input  logic                  OVF_CLR
);

  localparam int unsigned PTR_W = $clog2(WFIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [SYNC_STAGES-1:0] cs_sync, rd_sync, wr_sync;
  logic                   cs_s, rd_s, wr_s;
  logic                   cs_d, rd_d, wr_d;
  logic                   rd_evt, wr_evt;

  logic [DATA_W-1:0]      ch_data [NCH];
  logic [DATA_W-1:0]      rd_word;
  logic [NCH-1:0]         sel_onehot;

  logic [ADDR_W-1:0]      q_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0]      q_data [WFIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   full, pop, push_ok, ovf_set;

  // Strobes idle high, so reset fills the synchronisers with 1 so that a
  // strobe already low at release shows up as a single falling edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cs_sync <= '1;
      rd_sync <= '1;
      wr_sync <= '1;
      cs_d    <= 1'b1;
      rd_d    <= 1'b1;
      wr_d    <= 1'b1;
    end else begin
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], CS};
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], RD};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], WR};
      cs_d    <= cs_s;
      rd_d    <= rd_s;
      wr_d    <= wr_s;
    end
  end

  assign cs_s = cs_sync[SYNC_STAGES-1];
  assign rd_s = rd_sync[SYNC_STAGES-1];
  assign wr_s = wr_sync[SYNC_STAGES-1];

  assign rd_evt = ~cs_s & rd_d & ~rd_s;
  // Writes commit on the trailing WR edge; CS is qualified one cycle back
  // because the host may release CS together with WR.
  assign wr_evt = ~cs_d & ~wr_d & wr_s;

  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      ch_data[k] = RD_DATA[k*DATA_W +: DATA_W];
    end
    rd_word       = ch_data[A];
    sel_onehot    = '0;
    sel_onehot[A] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      D_OUT  <= '0;
      D_OE   <= 1'b0;
      RD_SEL <= '0;
    end else begin
      D_OE   <= ~cs_s & ~rd_s & wr_s;
      RD_SEL <= rd_evt ? sel_onehot : '0;
      if (rd_evt) begin
        D_OUT <= rd_word;
      end
    end
  end

  assign full     = (count == CNT_W'(WFIFO_DEPTH));
  assign WR_VALID = (count != '0);
  assign pop      = WR_VALID & WR_READY;
  assign push_ok  = wr_evt & (~full | pop);
  assign ovf_set  = wr_evt & full & ~pop;

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      q_addr[wr_ptr] <= A;
      q_data[wr_ptr] <= D_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      OVF <= 1'b0;
    end else if (ovf_set) begin
      OVF <= 1'b1;
    end else if (OVF_CLR) begin
      OVF <= 1'b0;
    end
  end

  assign WR_ADDR = q_addr[rd_ptr];
  assign WR_DATA = q_data[rd_ptr];

endmodule
